// File: rtl/div_app_seq.sv
// Sequential approximate divider: leading-one mantissa windows, radix-2 restoring
// mantissa divide (one quotient bit per cycle), then exponent rescale with saturation.
module div_app_seq #(
  parameter int IN_W = 16,
  parameter int ND_K = 12,
  parameter int DV_K = 6,
  parameter int F    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*IN_W-1:0] n_w,
  input  logic [IN_W-1:0]   d_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*IN_W-1:0] q_w,
  output logic              dz_w
);
  localparam int ITER = ND_K + F;
  localparam int QW   = 2 * IN_W;
  localparam int WW   = QW + ITER;
  localparam int EW   = $clog2(QW + ND_K + F) + 2;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [2:0] {IDLE, NORM, DIV, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [QW-1:0]         n_p0;
  logic [IN_W-1:0]       d_p0;
  logic [ND_K-1:0]       mn_c;
  logic [DV_K-1:0]       md_c, md_p1;
  logic signed [EW-1:0]  en_c, ed_c, en_p1, ed_p1;
  logic                  dz_p1;
  logic [ITER-1:0]       dvd_p2, qm_p2;
  logic [DV_K:0]         rem_p2;
  logic [DV_K+1:0]       rem_sh, diff;
  logic [QW-1:0]         q_r;
  logic                  dz_r;

  function automatic logic signed [EW-1:0] lead_one(input logic [QW-1:0] v);
    lead_one = '0;
    for (int i = 0; i < QW; i++) begin
      if (v[i]) lead_one = EW'(i);
    end
  endfunction

  // Shift the mantissa quotient by a signed exponent; any bit pushed past the
  // top of the quotient saturates the whole result to all ones.
  function automatic logic [QW-1:0] rescale_sat(input logic [ITER-1:0] qm,
                                                input logic signed [EW-1:0] s);
    logic [WW-1:0] wide;
    logic [EW-1:0] mag;
    logic          ovf;
    wide = {{QW{1'b0}}, qm};
    ovf  = 1'b0;
    if (s >= 0) begin
      mag  = s;
      wide = wide << mag;
      ovf  = (|wide[WW-1:QW]) || ((mag >= EW'(QW)) && (|qm));
    end else begin
      mag  = -s;
      wide = wide >> mag;
    end
    rescale_sat = ovf ? '1 : wide[QW-1:0];
  endfunction

  // Stage p0 -> p1: leading-one windowing, LSB forced to 1 on truncation
  always_comb begin
    en_c = '0;
    ed_c = '0;
    mn_c = n_p0[ND_K-1:0];
    md_c = d_p0[DV_K-1:0];
    if (|n_p0[QW-1:ND_K]) begin
      en_c = lead_one(n_p0) - EW'(ND_K - 1);
      mn_c = ND_K'(n_p0 >> en_c) | ND_K'(1);
    end
    if (|d_p0[IN_W-1:DV_K]) begin
      ed_c = lead_one(QW'(d_p0)) - EW'(DV_K - 1);
      md_c = DV_K'(d_p0 >> ed_c) | DV_K'(1);
    end
  end

  // Stage p2: one restoring step; the borrow-out selects restore
  always_comb begin
    rem_sh = {rem_p2, dvd_p2[ITER-1]};
    diff   = rem_sh - {2'b00, md_p1};
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE:    if (in_valid) state_nxt = NORM;
      NORM:    state_nxt = DIV;
      DIV:     if (cnt == '0) state_nxt = SHIFT;
      SHIFT:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      n_p0   <= '0;
      d_p0   <= '0;
      md_p1  <= '0;
      en_p1  <= '0;
      ed_p1  <= '0;
      dz_p1  <= 1'b0;
      dvd_p2 <= '0;
      qm_p2  <= '0;
      rem_p2 <= '0;
      q_r    <= '0;
      dz_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            n_p0 <= n_w;
            d_p0 <= d_w;
          end
        end
        NORM: begin
          dvd_p2 <= {mn_c, {F{1'b0}}};
          md_p1  <= md_c;
          en_p1  <= en_c;
          ed_p1  <= ed_c;
          dz_p1  <= (d_p0 == '0);
          rem_p2 <= '0;
          qm_p2  <= '0;
          cnt    <= CW'(ITER - 1);
        end
        DIV: begin
          dvd_p2 <= {dvd_p2[ITER-2:0], 1'b0};
          if (diff[DV_K+1]) begin
            rem_p2 <= rem_sh[DV_K:0];
            qm_p2  <= {qm_p2[ITER-2:0], 1'b0};
          end else begin
            rem_p2 <= diff[DV_K:0];
            qm_p2  <= {qm_p2[ITER-2:0], 1'b1};
          end
          cnt <= cnt - 1'b1;
        end
        SHIFT: begin
          q_r  <= dz_p1 ? '1 : rescale_sat(qm_p2, en_p1 - ed_p1 - EW'(F));
          dz_r <= dz_p1;
        end
        default: ;
      endcase
    end
  end

  assign q_w  = q_r;
  assign dz_w = dz_r;

endmodule
